// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
// Frame-atomic two-source arbiter feeding a single TX FIFO write port.
// A source owns the FIFO from its first beat to its last. The final beat is
// written with eod=1. Frames longer than MAX_FRAME_LEN are cut at the limit,
// and the rest of the frame is drained and discarded. GAP_CYCLES idle cycles
// separate consecutive frames.
// Build option: define ARB_FIXED_PRIO_EN to make source 0 win every IDLE
// arbitration in which it is valid. The default build is round-robin.
module eth_tx_frame_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int GAP_CYCLES    = 2,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  input  logic                  s0_last,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  input  logic                  s1_last,
  output logic                  s1_ready,
  output logic [DATA_WIDTH:0]   fifo_din,
  output logic                  fifo_wen,
  input  logic                  fifo_full,
  input  logic                  fifo_afull,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  trunc_pulse,
  output logic                  ovf_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int                   GAP_W     = $clog2(GAP_CYCLES) + 1;
  localparam logic [LEN_WIDTH-1:0] LAST_BEAT = LEN_WIDTH'(MAX_FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]     GAP_END   = GAP_W'(GAP_CYCLES - 1);

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [GAP_W-1:0]      gap_cnt;

  logic                  owner;      // 0 = source 0, 1 = source 1
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_valid;
  logic                  cur_last;
  logic                  cur_ready;
  logic                  accept;
  logic                  at_limit;
  logic                  xfer_open;
  logic                  req_any;
  logic                  win;        // IDLE winner: 0 = source 0, 1 = source 1

  // The owner is whichever grant bit is set. grant is 00 outside XFER/DRAIN,
  // and both readys are gated there, so the owner value does not matter then.
  assign owner     = grant[1];
  assign cur_data  = owner ? s1_data  : s0_data;
  assign cur_valid = owner ? s1_valid : s0_valid;
  assign cur_last  = owner ? s1_last  : s0_last;

  // XFER honours almost-full backpressure. DRAIN swallows beats unconditionally
  // because nothing is written to the FIFO.
  assign xfer_open = (state == ST_XFER) && !fifo_afull;
  assign s0_ready  = grant[0] && (xfer_open || (state == ST_DRAIN));
  assign s1_ready  = grant[1] && (xfer_open || (state == ST_DRAIN));
  assign cur_ready = owner ? s1_ready : s0_ready;
  assign accept    = cur_valid && cur_ready;

  // Beat number MAX_FRAME_LEN is being accepted when the count still shows one less.
  assign at_limit  = (beat_cnt == LAST_BEAT);
  assign busy      = (state != ST_IDLE);
  assign req_any   = s0_valid || s1_valid;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: source 0 wins whenever it is requesting.
  assign win = !s0_valid;
`else
  logic last_grant;

  // Round-robin: on a tie the source that did not own the previous frame wins.
  assign win = (s0_valid && s1_valid) ? !last_grant : s1_valid;

  // Record the owner when its frame ends. This covers both the normal end and the end of a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   last_grant <= 1'b1;
    else if (accept && cur_last) last_grant <= owner;
  end
`endif

  // Frame FSM, beat/gap counters, registered FIFO write port and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      grant       <= 2'b00;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      fifo_din    <= '0;
      fifo_wen    <= 1'b0;
      trunc_pulse <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      // NOTE: every register here is updated with <= so that all of them sample
      // the same pre-edge values. The single-cycle pulses default low first and
      // are raised only below.
      fifo_wen    <= 1'b0;
      trunc_pulse <= 1'b0;

      // A write presented while the FIFO reports full is still issued. It is flagged sticky.
      if (fifo_wen && fifo_full) ovf_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!fifo_afull && req_any) begin
            grant <= win ? 2'b10 : 2'b01;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            fifo_wen <= 1'b1;
            fifo_din <= {cur_last || at_limit, cur_data};
            if (cur_last) begin
              state    <= ST_GAP;
              grant    <= 2'b00;
              beat_cnt <= '0;
              gap_cnt  <= '0;
            end else if (at_limit) begin
              state       <= ST_DRAIN;
              trunc_pulse <= 1'b1;
              beat_cnt    <= beat_cnt + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept && cur_last) begin
            state    <= ST_GAP;
            grant    <= 2'b00;
            beat_cnt <= '0;
            gap_cnt  <= '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_END) state   <= ST_IDLE;
          else                    gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
